screen_sequencer: RTL and testbench

Parametrised game-screen sequencer for the snake top level. It owns the START / PLAY / PAUSE / END game flow, driven by strobed IR commands and the game-over flag. It captures the row-serial game grid into a tear-free double buffer and selects the frame sent to the matrix display driver. It also keeps the current score and a session high score.

---
 rtl/screen_sequencer_if.sv | 45 ++++
 rtl/screen_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_screen_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_sequencer_if.sv
// screen_sequencer_if
//   Bundles the command, game, row-serial grid and display/score signals of
//   the screen sequencer.
//   master : game top level (drives commands, game status and grid rows)
//   slave  : screen_sequencer (drives display frame, state and scores)
//   Signals:
//     cmd/cmd_valid       decoded IR word and its one-cycle strobe
//     game_over/length    status from the snake game
//     row_data/row_idx/row_valid  one grid row per valid cycle
//     disp_grid           frame to display, row r = [r*COLS +: COLS]
//     state/game_en/game_rst      game flow outputs
//     score/high_score    current and best score
interface screen_sequencer_if #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int CMD_W   = 32,
    parameter int LEN_W   = 8,
    parameter int SCORE_W = 12
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CMD_W-1:0]     cmd;
    logic                 cmd_valid;
    logic                 game_over;
    logic [LEN_W-1:0]     length;
    logic [COLS-1:0]      row_data;
    logic [IDX_W-1:0]     row_idx;
    logic                 row_valid;
    logic [ROWS*COLS-1:0] disp_grid;
    logic [1:0]           state;
    logic                 game_en;
    logic                 game_rst;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   high_score;

    modport master (
        output cmd, cmd_valid, game_over, length, row_data, row_idx, row_valid,
        input  disp_grid, state, game_en, game_rst, score, high_score
    );

    modport slave (
        input  cmd, cmd_valid, game_over, length, row_data, row_idx, row_valid,
        output disp_grid, state, game_en, game_rst, score, high_score
    );
endinterface

// File: rtl/screen_sequencer.sv
// screen_sequencer
//   Game-screen sequencer: owns the START / PLAY / PAUSE / END flow, captures
//   the row-serial game grid into a tear-free double buffer, selects the frame
//   shown on the matrix display and keeps the current and high score.
//   Ports:
//     CLOCK_50  system clock
//     reset_n   synchronous active-low reset
//     bus       screen_sequencer_if slave (commands, rows, display, scores)
//   All outputs are registered.
module screen_sequencer #(
    parameter int                   ROWS          = 16,
    parameter int                   COLS          = 16,
    parameter int                   CMD_W         = 32,
    parameter logic [CMD_W-1:0]     START_CMD     = 32'h20DF_22DD,
    parameter logic [CMD_W-1:0]     PAUSE_CMD     = 32'h20DF_5AA5,
    parameter int                   LEN_W         = 8,
    parameter int                   SCORE_W       = 12,
    parameter int                   SCORE_PER_LEN = 5,
    parameter int                   HOLDOFF       = 50_000_000,
    parameter logic [ROWS*COLS-1:0] START_GRID    = {(ROWS*COLS/2){2'b10}},
    parameter logic [ROWS*COLS-1:0] END_GRID      = {(ROWS*COLS){1'b1}}
) (
    input logic                CLOCK_50,
    input logic                reset_n,
    screen_sequencer_if.slave  bus
);

    localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GRID_W = ROWS * COLS;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int PROD_W = LEN_W + 32;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
    // One extra bit so that ROWS itself is representable for the range check.
    localparam logic [IDX_W:0]    ROWS_LIM  = (IDX_W + 1)'(ROWS);
    localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(ROWS - 1);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic [HOLD_W-1:0]  hold_q,       hold_d;
    logic [GRID_W-1:0]  back_q,       back_d;
    logic [GRID_W-1:0]  front_q,      front_d;
    logic [GRID_W-1:0]  disp_q,       disp_d;
    logic [SCORE_W-1:0] score_q,      score_d;
    logic [SCORE_W-1:0] high_q,       high_d;
    logic               game_en_q,    game_en_d;
    logic               game_rst_q,   game_rst_d;

    logic               start_hit_s;
    logic               pause_hit_s;
    logic               in_range_s;
    logic [PROD_W-1:0]  prod_s;
    logic [SCORE_W-1:0] best_s;

    // Command decode, row range check, score product and running best.
    always_comb begin
        start_hit_s = bus.cmd_valid && (bus.cmd == START_CMD);
        pause_hit_s = bus.cmd_valid && (bus.cmd == PAUSE_CMD);
        in_range_s  = ({1'b0, bus.row_idx} < ROWS_LIM);
        prod_s      = PROD_W'(bus.length) * PROD_W'(SCORE_PER_LEN);
        best_s      = (score_q > high_q) ? score_q : high_q;
    end

    // Next-state logic: game flow, holdoff, capture buffers, scores, outputs.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        back_d     = back_q;
        front_d    = front_q;
        score_d    = score_q;
        high_d     = high_q;
        game_rst_d = 1'b0;

        case (state_q)
            S_START: begin
                if (start_hit_s) begin
                    state_d    = S_PLAY;
                    game_rst_d = 1'b1;
                    score_d    = {SCORE_W{1'b0}};
                end else begin
                    state_d = S_START;
                end
            end
            S_PLAY: begin
                score_d = prod_s[SCORE_W-1:0];
                if (bus.game_over) begin
                    state_d = S_END;
                    hold_d  = HOLD_LOAD;
                    high_d  = best_s;
                end else if (pause_hit_s) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_PAUSE: begin
                if (bus.game_over) begin
                    state_d = S_END;
                    hold_d  = HOLD_LOAD;
                    high_d  = best_s;
                end else if (pause_hit_s) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_END: begin
                // START is only honoured once the holdoff has drained.
                if (hold_q != {HOLD_W{1'b0}}) begin
                    hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                end else if (start_hit_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_END;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase

        // Rows land in the back buffer; the last row publishes the whole
        // frame (including itself) to the front buffer in the same cycle.
        if ((state_q == S_PLAY) && bus.row_valid && in_range_s) begin
            back_d[bus.row_idx*COLS +: COLS] = bus.row_data;
            if (bus.row_idx == LAST_ROW) begin
                front_d = back_d;
            end else begin
                front_d = front_q;
            end
        end else begin
            back_d = back_q;
        end

        // Outputs follow the next state so they change with the transition.
        case (state_d)
            S_START: disp_d = START_GRID;
            S_END:   disp_d = END_GRID;
            S_PLAY:  disp_d = front_d;
            S_PAUSE: disp_d = front_d;
            default: disp_d = START_GRID;
        endcase
        game_en_d = (state_d == S_PLAY);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= S_START;
            hold_q     <= {HOLD_W{1'b0}};
            back_q     <= {GRID_W{1'b0}};
            front_q    <= {GRID_W{1'b0}};
            disp_q     <= START_GRID;
            score_q    <= {SCORE_W{1'b0}};
            high_q     <= {SCORE_W{1'b0}};
            game_en_q  <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            back_q     <= back_d;
            front_q    <= front_d;
            disp_q     <= disp_d;
            score_q    <= score_d;
            high_q     <= high_d;
            game_en_q  <= game_en_d;
            game_rst_q <= game_rst_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.disp_grid  = disp_q;
    assign bus.game_en    = game_en_q;
    assign bus.game_rst   = game_rst_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer
//   Randomised and directed stimulus against a behavioural model of the
//   screen sequencer. ROWS=12 is used so that 4-bit row indices 12..15 are
//   out-of-range values that must be discarded; HOLDOFF=10 keeps END short.
module tb_screen_sequencer;

    localparam int ROWS    = 12;
    localparam int COLS    = 16;
    localparam int CMD_W   = 32;
    localparam int LEN_W   = 10;
    localparam int SCORE_W = 12;
    localparam int HOLDOFF = 10;
    localparam int GW      = ROWS * COLS;

    localparam logic [31:0]   START_C = 32'h20DF_22DD;
    localparam logic [31:0]   PAUSE_C = 32'h20DF_5AA5;
    localparam logic [GW-1:0] SG      = {12{16'hA55A}};
    localparam logic [GW-1:0] EG      = {12{16'h0FF0}};
    localparam logic [GW-1:0] DIAG    = 192'h0800_0400_0200_0100_0080_0040_0020_0010_0008_0004_0002_0001;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    screen_sequencer_if #(
        .ROWS(ROWS), .COLS(COLS), .CMD_W(CMD_W), .LEN_W(LEN_W), .SCORE_W(SCORE_W)
    ) bus ();

    screen_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .CMD_W(CMD_W),
        .START_CMD(START_C), .PAUSE_CMD(PAUSE_C),
        .LEN_W(LEN_W), .SCORE_W(SCORE_W), .SCORE_PER_LEN(5),
        .HOLDOFF(HOLDOFF), .START_GRID(SG), .END_GRID(EG)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: game phase (0..3), row arrays, scores, END age.
    int              m_state;
    logic [COLS-1:0] m_back  [ROWS];
    logic [COLS-1:0] m_front [ROWS];
    int              m_score;
    int              m_high;
    int              m_age;
    bit              m_rst;

    task automatic model_step();
        bit start;
        bit pause;
        int old_score;
        int idx;
        if (!rst_n) begin
            m_state = 0;
            m_score = 0;
            m_high  = 0;
            m_age   = 0;
            m_rst   = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                m_back[r]  = '0;
                m_front[r] = '0;
            end
            return;
        end
        start     = bus.cmd_valid && (bus.cmd == START_C);
        pause     = bus.cmd_valid && (bus.cmd == PAUSE_C);
        old_score = m_score;
        idx       = int'(bus.row_idx);
        m_rst     = 1'b0;
        if (m_state == 1 && bus.row_valid && idx < ROWS) begin
            m_back[idx] = bus.row_data;
            if (idx == ROWS - 1) m_front = m_back;
        end
        if (m_state == 1) m_score = (int'(bus.length) * 5) % 4096;
        case (m_state)
            0: if (start) begin m_state = 1; m_rst = 1'b1; m_score = 0; end
            1, 2: begin
                if (bus.game_over) begin
                    m_state = 3;
                    m_age   = 0;
                    if (old_score > m_high) m_high = old_score;
                end else if (pause) begin
                    m_state = (m_state == 1) ? 2 : 1;
                end
            end
            3: begin
                m_age = m_age + 1;
                if (start && m_age >= HOLDOFF) m_state = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [GW-1:0] exp_disp();
        logic [GW-1:0] v;
        v = '0;
        if (m_state == 0) v = SG;
        else if (m_state == 3) v = EG;
        else for (int r = 0; r < ROWS; r++) v[r*COLS +: COLS] = m_front[r];
        return v;
    endfunction

    task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: the model samples the same inputs as the DUT.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] c);
        bus.cmd       = c;
        bus.cmd_valid = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("state",      GW'(bus.state),      GW'(m_state[1:0]));
                chk("game_en",    GW'(bus.game_en),    GW'(m_state == 1));
                chk("game_rst",   GW'(bus.game_rst),   GW'(m_rst));
                chk("score",      GW'(bus.score),      GW'(m_score));
                chk("high_score", GW'(bus.high_score), GW'(m_high));
                chk("disp_grid",  bus.disp_grid,       exp_disp());
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        bus.cmd = '0; bus.cmd_valid = 1'b0; bus.game_over = 1'b0;
        bus.length = '0; bus.row_data = '0; bus.row_idx = '0; bus.row_valid = 1'b0;
        cycle();
        cycle();
        chk_en = 1'b1;
        chk("rst_state", GW'(bus.state), GW'(2'd0));
        chk("rst_disp",  bus.disp_grid, SG);
        chk("rst_en",    GW'(bus.game_en), GW'(1'b0));
        chk("rst_score", GW'(bus.score), GW'(12'd0));
        rst_n = 1'b1;
        cycle();

        // START -> PLAY with a one-cycle game_rst.
        set_cmd(START_C); cycle(); bus.cmd_valid = 1'b0;
        chk("play_state", GW'(bus.state), GW'(2'd1));
        chk("play_rst",   GW'(bus.game_rst), GW'(1'b1));
        chk("play_en",    GW'(bus.game_en), GW'(1'b1));
        cycle();
        chk("rst_pulse_end", GW'(bus.game_rst), GW'(1'b0));

        // Diagonal frame, visible only after the last row.
        bus.row_valid = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            bus.row_idx  = 4'(r);
            bus.row_data = 16'h0001 << r;
            cycle();
            if (r == ROWS - 2) chk("no_tear", bus.disp_grid, {GW{1'b0}});
        end
        chk("diag", bus.disp_grid, DIAG);
        bus.row_idx = 4'd12; bus.row_data = 16'hFFFF; cycle();
        bus.row_idx = 4'd11; bus.row_data = 16'h0800; cycle();
        chk("oob_row", bus.disp_grid, DIAG);
        bus.row_valid = 1'b0;

        // Score and END with high score.
        bus.length = 10'd7; cycle(); cycle();
        chk("score35", GW'(bus.score), GW'(12'd35));
        bus.game_over = 1'b1; cycle(); bus.game_over = 1'b0;
        chk("end_state", GW'(bus.state), GW'(2'd3));
        chk("end_disp",  bus.disp_grid, EG);
        chk("high35",    GW'(bus.high_score), GW'(12'd35));

        // Holdoff: START at entry+5 ignored, at entry+12 honoured.
        for (int i = 0; i < 4; i++) cycle();
        set_cmd(START_C); cycle(); bus.cmd_valid = 1'b0;
        chk("holdoff_ign", GW'(bus.state), GW'(2'd3));
        for (int i = 0; i < 6; i++) cycle();
        set_cmd(START_C); cycle(); bus.cmd_valid = 1'b0;
        chk("holdoff_done", GW'(bus.state), GW'(2'd0));
        chk("start_disp",   bus.disp_grid, SG);

        // Second game with lower score keeps the high score.
        set_cmd(START_C); cycle(); bus.cmd_valid = 1'b0;
        bus.length = 10'd3; cycle(); cycle();
        bus.game_over = 1'b1; cycle(); bus.game_over = 1'b0;
        chk("high_keep", GW'(bus.high_score), GW'(12'd35));
        for (int i = 0; i < 10; i++) cycle();
        set_cmd(START_C); cycle();
        set_cmd(START_C); cycle(); bus.cmd_valid = 1'b0;

        // Pause freezes the frame.
        set_cmd(PAUSE_C); cycle(); bus.cmd_valid = 1'b0;
        chk("pause_state", GW'(bus.state), GW'(2'd2));
        chk("pause_en",    GW'(bus.game_en), GW'(1'b0));
        bus.row_valid = 1'b1; bus.row_idx = 4'd11; bus.row_data = 16'hFFFF; cycle();
        bus.row_valid = 1'b0;
        set_cmd(PAUSE_C); cycle(); bus.cmd_valid = 1'b0;
        chk("resume", GW'(bus.state), GW'(2'd1));

        // game_over with PAUSE_CMD goes to END.
        bus.game_over = 1'b1; set_cmd(PAUSE_C); cycle();
        bus.game_over = 1'b0; bus.cmd_valid = 1'b0;
        chk("go_pause", GW'(bus.state), GW'(2'd3));
        for (int i = 0; i < 10; i++) cycle();
        set_cmd(START_C); cycle();
        set_cmd(32'h20DF_0000); cycle(); bus.cmd_valid = 1'b0;
        chk("bad_cmd", GW'(bus.state), GW'(2'd0));

        // Reset while paused.
        set_cmd(START_C); cycle();
        set_cmd(PAUSE_C); cycle(); bus.cmd_valid = 1'b0;
        rst_n = 1'b0; cycle();
        chk("prst_state", GW'(bus.state), GW'(2'd0));
        chk("prst_disp",  bus.disp_grid, SG);
        chk("prst_high",  GW'(bus.high_score), GW'(12'd0));
        rst_n = 1'b1; cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst_n         = ($urandom_range(0, 499) != 0);
            sel           = int'($urandom_range(0, 2));
            bus.cmd       = (sel == 0) ? START_C : (sel == 1) ? PAUSE_C : 32'($urandom());
            bus.cmd_valid = ($urandom_range(0, 3) == 0);
            bus.game_over = ($urandom_range(0, 15) == 0);
            bus.length    = 10'($urandom_range(0, 1023));
            bus.row_valid = ($urandom_range(0, 1) == 1);
            bus.row_idx   = 4'($urandom_range(0, 15));
            bus.row_data  = 16'($urandom_range(0, 65535));
            cycle();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
